// File: rtl/pipeline_mem_withloadstore_pkg.sv
// Data-memory op codes shared between the decoder and the MEM stage,
// plus small classifiers used by the MEM-stage lane logic.
package pipeline_mem_withloadstore_pkg;

  localparam logic [3:0] DMEM_NO  = 4'd0;
  localparam logic [3:0] DMEM_LB  = 4'd1;
  localparam logic [3:0] DMEM_LH  = 4'd2;
  localparam logic [3:0] DMEM_LW  = 4'd3;
  localparam logic [3:0] DMEM_LBU = 4'd4;
  localparam logic [3:0] DMEM_LHU = 4'd5;
  localparam logic [3:0] DMEM_SB  = 4'd6;
  localparam logic [3:0] DMEM_SH  = 4'd7;
  localparam logic [3:0] DMEM_SW  = 4'd8;

  function automatic logic is_store(input logic [3:0] op);
    return (op == DMEM_SB) || (op == DMEM_SH) || (op == DMEM_SW);
  endfunction

endpackage

// File: rtl/pipeline_mem_withloadstore_dmem_byte_ram.sv
// Word-organised data RAM with per-byte write enables and an asynchronous read port.
// Contents are never cleared; only written lanes change.
module dmem_byte_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pipeline_mem_withloadstore.sv
// MEM stage of the RV32 pipeline: EX/MEM register, byte-lane store steering,
// and load lane select / extension around a byte-enabled data RAM.
module pipeline_mem_withloadstore
  import pipeline_mem_withloadstore_pkg::*;
#(
  parameter int DMEM_ADDR_W = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] alu_result_e_i,
  input  logic [3:0]  dmem_type_e_i,
  input  logic [31:0] rs1_e_i,
  input  logic [31:0] extended_imm_e_i,
  input  logic [31:0] pc_plus_e_i,
  input  logic        reg_write_en_e_i,
  input  logic [4:0]  rd_idx_e_i,
  input  logic [3:0]  result_src_e_i,
  output logic [31:0] mem_read_data_m_o,
  output logic [31:0] alu_result_m_o,
  output logic [31:0] extended_imm_m_o,
  output logic [31:0] pc_plus_m_o,
  output logic        reg_write_en_m_o,
  output logic [4:0]  rd_idx_m_o,
  output logic [3:0]  result_src_m_o
);

  logic        [31:0] alu_q, imm_q, pc_q;
  logic signed [31:0] store_data_q;
  logic        [3:0]  type_q, rsrc_q;
  logic        [4:0]  rd_q;
  logic               rwe_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // EX/MEM boundary: resetn is active-high despite its name
  always_ff @(posedge clk) begin
    if (resetn) begin
      alu_q        <= '0;
      type_q       <= DMEM_NO;
      store_data_q <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      rwe_q        <= 1'b0;
      rd_q         <= '0;
      rsrc_q       <= '0;
    end else begin
      alu_q        <= alu_result_e_i;
      type_q       <= dmem_type_e_i;
      store_data_q <= rs1_e_i;
      imm_q        <= extended_imm_e_i;
      pc_q         <= pc_plus_e_i;
      rwe_q        <= reg_write_en_e_i;
      rd_q         <= rd_idx_e_i;
      rsrc_q       <= result_src_e_i;
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = store_data_q;
    if (!resetn && is_store(type_q)) begin
      case (type_q)
        DMEM_SW: be_d = 4'b1111;
        DMEM_SH: begin
          be_d    = alu_q[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{store_data_q[15:0]}};
        end
        default: begin
          be_d    = 4'b0001 << alu_q[1:0];
          wdata_d = {4{store_data_q[7:0]}};
        end
      endcase
    end
  end

  dmem_byte_ram #(
    .ADDR_W (DMEM_ADDR_W)
  ) u_dmem (
    .clk_i   (clk),
    .be_i    (be_d),
    .addr_i  (alu_q[DMEM_ADDR_W+1:2]),
    .wdata_i (wdata_d),
    .rdata_o (rdata)
  );

  always_comb begin
    case (alu_q[1:0])
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = alu_q[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    mem_read_data_m_o = '0;
    case (type_q)
      DMEM_LB:  mem_read_data_m_o = {{24{byte_sel[7]}}, byte_sel};
      DMEM_LH:  mem_read_data_m_o = {{16{half_sel[15]}}, half_sel};
      DMEM_LW:  mem_read_data_m_o = rdata;
      DMEM_LBU: mem_read_data_m_o = {24'd0, byte_sel};
      DMEM_LHU: mem_read_data_m_o = {16'd0, half_sel};
      default:  mem_read_data_m_o = '0;
    endcase
  end

  assign alu_result_m_o   = alu_q;
  assign extended_imm_m_o = imm_q;
  assign pc_plus_m_o      = pc_q;
  assign reg_write_en_m_o = rwe_q;
  assign rd_idx_m_o       = rd_q;
  assign result_src_m_o   = rsrc_q;

endmodule

// File: tb/tb_pipeline_mem_withloadstore.sv
// Scoreboard bench for the MEM stage: each driven vector queues the outputs
// expected one edge later; a negedge monitor pops and compares them.
module tb_pipeline_mem_withloadstore;
  import pipeline_mem_withloadstore_pkg::*;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] alu_result_e, rs1_e, extended_imm_e, pc_plus_e;
  logic [3:0]  dmem_type_e, result_src_e;
  logic        reg_write_en_e;
  logic [4:0]  rd_idx_e;
  logic [31:0] mem_read_data_m, alu_result_m, extended_imm_m, pc_plus_m;
  logic        reg_write_en_m;
  logic [4:0]  rd_idx_m;
  logic [3:0]  result_src_m;

  pipeline_mem_withloadstore #(.DMEM_ADDR_W(AW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .alu_result_e_i    (alu_result_e),
    .dmem_type_e_i     (dmem_type_e),
    .rs1_e_i           (rs1_e),
    .extended_imm_e_i  (extended_imm_e),
    .pc_plus_e_i       (pc_plus_e),
    .reg_write_en_e_i  (reg_write_en_e),
    .rd_idx_e_i        (rd_idx_e),
    .result_src_e_i    (result_src_e),
    .mem_read_data_m_o (mem_read_data_m),
    .alu_result_m_o    (alu_result_m),
    .extended_imm_m_o  (extended_imm_m),
    .pc_plus_m_o       (pc_plus_m),
    .reg_write_en_m_o  (reg_write_en_m),
    .rd_idx_m_o        (rd_idx_m),
    .result_src_m_o    (result_src_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        rwe;
    logic [4:0]  rd;
    logic [3:0]  rsrc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_mem [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      check("rdata",  mem_read_data_m,        mon_e.rdata);
      check("alu",    alu_result_m,           mon_e.alu);
      check("imm",    extended_imm_m,         mon_e.imm);
      check("pc",     pc_plus_m,              mon_e.pc);
      check("rwe",    {31'd0, reg_write_en_m}, {31'd0, mon_e.rwe});
      check("rd",     {27'd0, rd_idx_m},       {27'd0, mon_e.rd});
      check("rsrc",   {28'd0, result_src_m},   {28'd0, mon_e.rsrc});
    end
  end

  task automatic vec_full(input logic rst, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd,
                          input logic [31:0] pc, input logic [31:0] imm, input logic rwe,
                          input logic [4:0] rd, input logic [3:0] rsrc);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rst; dmem_type_e = op; alu_result_e = addr; rs1_e = data;
    extended_imm_e = imm; pc_plus_e = pc; reg_write_en_e = rwe;
    rd_idx_e = rd; result_src_e = rsrc;
    e.due = cyc + 1;
    if (rst) begin
      e.rdata = '0; e.alu = '0; e.imm = '0; e.pc = '0; e.rwe = 1'b0; e.rd = '0; e.rsrc = '0;
    end else begin
      e.rdata = exp_rd; e.alu = addr; e.imm = imm; e.pc = pc; e.rwe = rwe; e.rd = rd; e.rsrc = rsrc;
    end
    sbq.push_back(e);
  endtask

  task automatic vec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_rd);
    vec_full(1'b0, op, addr, data, exp_rd, $urandom, $urandom, 1'($urandom),
             5'($urandom), 4'($urandom));
  endtask

  task automatic rst_vec();
    vec_full(1'b1, DMEM_SW, $urandom, $urandom, 32'd0, $urandom, $urandom, 1'b1, 5'd7, 4'd2);
  endtask

  function automatic logic [31:0] ld_ref(input logic [3:0] op, input logic [31:0] w, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = 16'(w >> (16 * a[1]));
    case (op)
      DMEM_LB:  return {{24{b[7]}}, b};
      DMEM_LH:  return {{16{h[15]}}, h};
      DMEM_LW:  return w;
      DMEM_LBU: return {24'd0, b};
      DMEM_LHU: return {16'd0, h};
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] st_ref(input logic [3:0] op, input logic [31:0] w,
                                         input logic [31:0] d, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    case (op)
      DMEM_SW: r = d;
      DMEM_SH: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      DMEM_SB: r[8*a +: 8] = d[7:0];
      default: r = w;
    endcase
    return r;
  endfunction

  initial begin
    resetn = 1'b1; dmem_type_e = '0; alu_result_e = '0; rs1_e = '0; extended_imm_e = '0;
    pc_plus_e = '0; reg_write_en_e = 1'b0; rd_idx_e = '0; result_src_e = '0;

    // reset held two cycles, then pass-through
    rst_vec();
    rst_vec();
    vec_full(1'b0, DMEM_NO, 32'h0000_0010, 32'h0, 32'h0, 32'h40, 32'h123, 1'b1, 5'd5, 4'd3);
    vec_full(1'b0, DMEM_NO, 32'h0000_0020, 32'h0, 32'h0, 32'h44, 32'h456, 1'b0, 5'd9, 4'd1);

    // sub-word stores
    vec(DMEM_SW, 32'd4, 32'h1234_5678, 32'h0);
    vec(DMEM_LW, 32'd4, 32'h0,         32'h1234_5678);
    vec(DMEM_SH, 32'd6, 32'hFFFF_FFFF, 32'h0);
    vec(DMEM_LW, 32'd4, 32'h0,         32'hFFFF_5678);
    vec(DMEM_SB, 32'd7, 32'hAAAA_AAAA, 32'h0);
    vec(DMEM_LW, 32'd4, 32'h0,         32'hAAFF_5678);

    // load extension
    vec(DMEM_LH,  32'd6, 32'h0, 32'hFFFF_AAFF);
    vec(DMEM_LHU, 32'd4, 32'h0, 32'h0000_5678);
    vec(DMEM_LB,  32'd5, 32'h0, 32'h0000_0056);
    vec(DMEM_LBU, 32'd7, 32'h0, 32'h0000_00AA);
    vec(DMEM_LB,  32'd7, 32'h0, 32'hFFFF_FFAA);
    vec(DMEM_LW,  32'd7, 32'h0, 32'hAAFF_5678);
    vec(DMEM_LHU, 32'd7, 32'h0, 32'h0000_AAFF);

    // back-to-back store then load, and non-load ops
    vec(DMEM_SW, 32'd8, 32'hDEAD_BEEF, 32'h0);
    vec(DMEM_LW, 32'd8, 32'h0,         32'hDEAD_BEEF);
    vec(DMEM_NO, 32'd8, 32'h0,         32'h0);
    vec(4'd12,   32'd8, 32'h0,         32'h0);

    // reset on the edge that would perform a store
    vec(DMEM_SW, 32'd12, 32'h1111_2222, 32'h0);
    vec(DMEM_SW, 32'd12, 32'h9999_9999, 32'h0);
    rst_vec();
    vec(DMEM_LW, 32'd12, 32'h0, 32'h1111_2222);

    // word index wraps
    vec(DMEM_SW, 32'd4 + 32'(4 * (2**AW)), 32'h5A5A_5A5A, 32'h0);
    vec(DMEM_LW, 32'd4, 32'h0, 32'h5A5A_5A5A);

    // random mix over eight words at 0x100
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = $urandom;
      vec(DMEM_SW, 32'h100 + 32'(4 * i), model_mem[i], 32'h0);
    end
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [2:0]  wi;
      logic [1:0]  ln;
      logic [31:0] d;
      op = 4'($urandom_range(0, 15));
      wi = 3'($urandom);
      ln = 2'($urandom);
      d  = $urandom;
      vec(op, 32'h100 + {27'd0, wi, ln}, d, ld_ref(op, model_mem[wi], ln));
      model_mem[wi] = st_ref(op, model_mem[wi], d, ln);
    end

    for (int i = 0; i < 5; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    #1;
    check("sb_drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
